// File: rtl/udp_tx_sched_pkg.sv
// Shared definitions for the udp_send transmit scheduler: state codes,
// frame-type select codes, address widths and timer sizing.
package udp_tx_sched_pkg;

   localparam int MAC_W = 48;
   localparam int IP_W  = 32;

   typedef enum logic [2:0] {
      SC_IDLE  = 3'd0,
      SC_SETUP = 3'd1,
      SC_GO    = 3'd2,
      SC_WAIT  = 3'd3,
      SC_BUSY  = 3'd4,
      SC_GAP   = 3'd5
   } sc_state_t;

   typedef enum logic {
      SC_SEL_UDP = 1'b0,
      SC_SEL_ARP = 1'b1
   } sc_sel_t;

   // Width of a saturating timer that must reach max(a, b)
   function automatic int tmr_width(input int a, input int b);
      return $clog2((a > b) ? a : b) + 1;
   endfunction

endpackage

// File: rtl/udp_tx_sched_if.sv
// Launch/status bundle between the scheduler (master) and udp_send (slave).
interface udp_tx_sched_if;
   import udp_tx_sched_pkg::*;

   logic             go;
   logic             arp;
   logic [MAC_W-1:0] dst_mac;
   logic [IP_W-1:0]  dst_ip;
   logic             s_en;

   modport master (output go, arp, dst_mac, dst_ip, input s_en);
   modport slave  (input go, arp, dst_mac, dst_ip, output s_en);
endinterface

// File: rtl/udp_tx_sched_arp_pend.sv
// One-entry ARP reply request latch. A request arriving while an entry is
// pending (and not being consumed) is dropped and reported with a pulse.
module udp_arp_pend
   import udp_tx_sched_pkg::*;
(
   input  logic             s_clk,
   input  logic             rst_n,
   input  logic             arp_req,
   input  logic [MAC_W-1:0] req_mac,
   input  logic [IP_W-1:0]  req_ip,
   input  logic             clr,
   output logic             pend,
   output logic [MAC_W-1:0] mac,
   output logic [IP_W-1:0]  ip,
   output logic             drop
);

   logic             pend_reg;
   logic [MAC_W-1:0] mac_reg;
   logic [IP_W-1:0]  ip_reg;
   logic             drop_reg;

   // Capture a new request when empty or when the old one is consumed this cycle
   always_ff @(posedge s_clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_reg <= 1'b0;
         mac_reg  <= '0;
         ip_reg   <= '0;
         drop_reg <= 1'b0;
      end else begin
         drop_reg <= arp_req && pend_reg && !clr;
         if (arp_req && (!pend_reg || clr)) begin
            pend_reg <= 1'b1;
            mac_reg  <= req_mac;
            ip_reg   <= req_ip;
         end else if (clr) begin
            pend_reg <= 1'b0;
         end
      end
   end

   assign pend = pend_reg;
   assign mac  = mac_reg;
   assign ip   = ip_reg;
   assign drop = drop_reg;

endmodule

// File: rtl/udp_tx_sched.sv
// Transmit scheduler in front of udp_send: alternates between pending ARP
// replies and ready UDP frames, sequences go/arp setup timing, watches s_en
// for frame start/end and holds off the next launch for the inter-frame gap.
module udp_tx_sched
   import udp_tx_sched_pkg::*;
#(
   parameter int FRAME_NIBBLES = 36,
   parameter int GAP_CLKS      = 24,
   parameter int START_TO      = 64,
   parameter int LVL_W         = 11
) (
   input  logic             s_clk,
   input  logic             rst_n,
   input  logic             arp_req,
   input  logic [MAC_W-1:0] arp_req_mac,
   input  logic [IP_W-1:0]  arp_req_ip,
   input  logic             udp_en,
   input  logic [LVL_W-1:0] fifo_level,
   input  logic [MAC_W-1:0] cfg_dst_mac,
   input  logic [IP_W-1:0]  cfg_dst_ip,
   udp_tx_sched_if.master   tx,
   output logic             busy,
   output logic             frame_done,
   output logic             arp_drop,
   output logic             start_err
);

   localparam int               TMR_W      = tmr_width(START_TO, GAP_CLKS);
   localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_TO - 1);
   localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CLKS - 1);
   localparam logic [TMR_W-1:0] TMR_MAX    = '1;
   localparam logic [LVL_W-1:0] FRAME_LVL  = LVL_W'(FRAME_NIBBLES);

   sc_state_t        state_reg, state_next;
   sc_sel_t          last_sel_reg, last_sel_next;
   logic [TMR_W-1:0] timer_reg, timer_next, timer_sat;
   logic             udp_rdy_reg;
   logic             go_next, arp_next, frame_done_next, start_err_next;
   logic [MAC_W-1:0] mac_next;
   logic [IP_W-1:0]  ip_next;

   logic             arp_pend, pend_clr, sel_arp, any_rdy;
   logic [MAC_W-1:0] pend_mac;
   logic [IP_W-1:0]  pend_ip;

   udp_arp_pend u_arp_pend (
      .s_clk   (s_clk),
      .rst_n   (rst_n),
      .arp_req (arp_req),
      .req_mac (arp_req_mac),
      .req_ip  (arp_req_ip),
      .clr     (pend_clr),
      .pend    (arp_pend),
      .mac     (pend_mac),
      .ip      (pend_ip),
      .drop    (arp_drop)
   );

   // When both sources are ready, pick the one not served last
   assign any_rdy   = arp_pend || udp_rdy_reg;
   assign sel_arp   = (arp_pend && udp_rdy_reg) ? (last_sel_reg == SC_SEL_UDP) : arp_pend;
   assign timer_sat = (timer_reg == TMR_MAX) ? timer_reg : timer_reg + 1'b1;

   // Next-state and registered-output decode
   always_comb begin
      state_next      = state_reg;
      last_sel_next   = last_sel_reg;
      timer_next      = timer_reg;
      go_next         = 1'b0;
      arp_next        = tx.arp;
      mac_next        = tx.dst_mac;
      ip_next         = tx.dst_ip;
      frame_done_next = 1'b0;
      start_err_next  = 1'b0;
      pend_clr        = 1'b0;
      case (state_reg)
         SC_IDLE: begin
            timer_next = '0;
            arp_next   = 1'b0;
            if (any_rdy) begin
               state_next    = SC_SETUP;
               arp_next      = sel_arp;
               mac_next      = sel_arp ? pend_mac : cfg_dst_mac;
               ip_next       = sel_arp ? pend_ip  : cfg_dst_ip;
               last_sel_next = sel_arp ? SC_SEL_ARP : SC_SEL_UDP;
               pend_clr      = sel_arp;
            end
         end
         SC_SETUP: begin
            state_next = SC_GO;
            go_next    = 1'b1;
            timer_next = '0;
         end
         SC_GO: begin
            // Timer is 0 in the go cycle, so it counts cycles since go
            state_next = SC_WAIT;
            arp_next   = 1'b0;
            timer_next = timer_sat;
         end
         SC_WAIT: begin
            if (tx.s_en) begin
               state_next = SC_BUSY;
            end else if (timer_reg == START_LAST) begin
               state_next     = SC_GAP;
               start_err_next = 1'b1;
               timer_next     = '0;
            end else begin
               timer_next = timer_sat;
            end
         end
         SC_BUSY: begin
            if (!tx.s_en) begin
               state_next      = SC_GAP;
               frame_done_next = 1'b1;
               timer_next      = '0;
            end
         end
         SC_GAP: begin
            if (timer_reg == GAP_LAST) begin
               state_next = SC_IDLE;
               timer_next = '0;
            end else begin
               timer_next = timer_sat;
            end
         end
         default: begin
            state_next = SC_IDLE;
            timer_next = '0;
         end
      endcase
   end

   // State, timer, readiness sample and output registers
   always_ff @(posedge s_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= SC_IDLE;
         last_sel_reg <= SC_SEL_UDP;
         timer_reg    <= '0;
         udp_rdy_reg  <= 1'b0;
         tx.go        <= 1'b0;
         tx.arp       <= 1'b0;
         tx.dst_mac   <= '0;
         tx.dst_ip    <= '0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
         start_err    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         last_sel_reg <= last_sel_next;
         timer_reg    <= timer_next;
         udp_rdy_reg  <= udp_en && (fifo_level >= FRAME_LVL);
         tx.go        <= go_next;
         tx.arp       <= arp_next;
         tx.dst_mac   <= mac_next;
         tx.dst_ip    <= ip_next;
         busy         <= (state_next != SC_IDLE);
         frame_done   <= frame_done_next;
         start_err    <= start_err_next;
      end
   end

endmodule
